rr_arbiter: RTL

RR_ARBITER -- requirements
Module: rr_arbiter

---
 rtl/rr_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with non-overlapping tenures and a per-tenure hold limit.
// A timed-out owner is forced off with a one-cycle preempt pulse; an idle cycle separates every tenure.

module rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    localparam int IW      = (N > 1) ? $clog2(N) : 1,
    localparam int HW      = $clog2(MAX_HOLD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          busy,
    output logic          preempt
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } state_t;

    state_t        state_r, state_nx_s;
    logic [IW-1:0] ptr_r, ptr_nx_s;
    logic [IW-1:0] owner_r, owner_nx_s;
    logic [HW-1:0] hold_cnt_r, hold_nx_s;
    logic [N-1:0]  gnt_r, gnt_nx_s;
    logic [IW-1:0] gnt_id_r, gnt_id_nx_s;
    logic          busy_r, busy_nx_s;
    logic          preempt_r, preempt_nx_s;

    logic [2*N-1:0] req2_s;
    logic [N-1:0]   rot_s;
    logic           win_found_s;
    int             win_off_s;
    int             win_sum_s;
    logic [IW-1:0]  win_idx_s;

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
        logic [N-1:0] v;
        v = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) v[i] = 1'b1;
            else               v[i] = 1'b0;
        end
        return v;
    endfunction

    // Winner search: rotate req so ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        req2_s      = {req, req} >> ptr_r;
        rot_s       = req2_s[N-1:0];
        win_found_s = |rot_s;
        win_off_s   = 0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot_s[j]) win_off_s = j;
            else          win_off_s = win_off_s;
        end
        win_sum_s = int'(ptr_r) + win_off_s;
        if (win_sum_s >= N) win_idx_s = IW'(win_sum_s - N);
        else                win_idx_s = IW'(win_sum_s);
    end

    // Next-state and next-output logic of the IDLE/GRANTED machine.
    always_comb begin
        state_nx_s   = state_r;
        ptr_nx_s     = ptr_r;
        owner_nx_s   = owner_r;
        hold_nx_s    = hold_cnt_r;
        gnt_nx_s     = gnt_r;
        preempt_nx_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_nx_s = ST_GRANTED;
                    owner_nx_s = win_idx_s;
                    hold_nx_s  = HW'(1);
                    gnt_nx_s   = onehot(win_idx_s);
                end else begin
                    gnt_nx_s  = {N{1'b0}};
                    hold_nx_s = {HW{1'b0}};
                end
            end
            ST_GRANTED: begin
                if (req[owner_r] && (hold_cnt_r != HW'(MAX_HOLD))) begin
                    hold_nx_s = hold_cnt_r + HW'(1);
                end else begin
                    // Release: voluntary drop or timeout; the pointer moves past the owner either way.
                    state_nx_s   = ST_IDLE;
                    gnt_nx_s     = {N{1'b0}};
                    hold_nx_s    = {HW{1'b0}};
                    preempt_nx_s = req[owner_r];
                    if (owner_r == IW'(N - 1)) ptr_nx_s = {IW{1'b0}};
                    else                       ptr_nx_s = owner_r + IW'(1);
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                gnt_nx_s   = {N{1'b0}};
                hold_nx_s  = {HW{1'b0}};
            end
        endcase
        busy_nx_s = (gnt_nx_s != {N{1'b0}});
        if (busy_nx_s) gnt_id_nx_s = owner_nx_s;
        else           gnt_id_nx_s = {IW{1'b0}};
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= {IW{1'b0}};
            owner_r    <= {IW{1'b0}};
            hold_cnt_r <= {HW{1'b0}};
            gnt_r      <= {N{1'b0}};
            gnt_id_r   <= {IW{1'b0}};
            busy_r     <= 1'b0;
            preempt_r  <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            ptr_r      <= ptr_nx_s;
            owner_r    <= owner_nx_s;
            hold_cnt_r <= hold_nx_s;
            gnt_r      <= gnt_nx_s;
            gnt_id_r   <= gnt_id_nx_s;
            busy_r     <= busy_nx_s;
            preempt_r  <= preempt_nx_s;
        end
    end

    assign gnt     = gnt_r;
    assign gnt_id  = gnt_id_r;
    assign busy    = busy_r;
    assign preempt = preempt_r;

    rr_arbiter_chk #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt_r),
        .busy    (busy_r),
        .preempt (preempt_r)
    );

endmodule

// Protocol checker for rr_arbiter: grant shape, causality, busy/preempt consistency and hold bound.
module rr_arbiter_chk #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    localparam int RW      = $clog2(MAX_HOLD + 1) + 1
) (
    input logic         clk,
    input logic         rst,
    input logic [N-1:0] req,
    input logic [N-1:0] gnt,
    input logic         busy,
    input logic         preempt
);

    logic          past_valid_r;
    logic [N-1:0]  gnt_q_r;
    logic [RW-1:0] run_r;

    // Past-valid flag and the length of the current run of an unchanged non-zero grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            past_valid_r <= 1'b0;
            gnt_q_r      <= {N{1'b0}};
            run_r        <= {RW{1'b0}};
        end else begin
            past_valid_r <= 1'b1;
            gnt_q_r      <= gnt;
            if (gnt == {N{1'b0}}) begin
                run_r <= {RW{1'b0}};
            end else if (gnt != gnt_q_r) begin
                run_r <= RW'(1);
            end else if (run_r <= RW'(MAX_HOLD)) begin
                run_r <= run_r + RW'(1);
            end else begin
                run_r <= run_r;
            end
        end
    end

    default clocking cb @(posedge clk);
    endclocking

    a_onehot: assert property (disable iff (rst) $onehot0(gnt));
    a_cause:  assert property (disable iff (rst)
                  past_valid_r |-> ((gnt & ~$past(gnt) & ~$past(req)) == {N{1'b0}}));
    a_busy:   assert property (disable iff (rst) busy == (gnt != {N{1'b0}}));
    a_pre:    assert property (disable iff (rst) preempt |-> (gnt == {N{1'b0}}));
    a_hold:   assert property (disable iff (rst) run_r <= RW'(MAX_HOLD));

endmodule
